// File: rtl/hog_overlay_pkg.sv
// hog_overlay_pkg: shared box record, commit-state encoding and coordinate defaults
// for the HOG detection-box overlay.
`default_nettype none

package hog_overlay_pkg;

  localparam int XW_DEF    = 11;
  localparam int YW_DEF    = 11;
  // Box coordinates are stored at this fixed width so one record type serves any XW/YW up to it.
  localparam int COORD_MAX = 16;

  typedef struct packed {
    logic                 en;
    logic [COORD_MAX-1:0] x0;
    logic [COORD_MAX-1:0] y0;
    logic [COORD_MAX-1:0] x1;
    logic [COORD_MAX-1:0] y1;
  } box_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_state_t;

endpackage

`default_nettype wire

// File: rtl/hog_box_hit.sv
// hog_box_hit: combinational border test of one pixel against one box
// (inside the outer rectangle, outside the THICK-inset inner rectangle).
`default_nettype none

module hog_box_hit
  import hog_overlay_pkg::*;
#(
  parameter int XW    = XW_DEF,
  parameter int YW    = YW_DEF,
  parameter int THICK = 2
) (
  input  box_t          box,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic          hit
);

  // Two spare bits: one for x0+THICK overflow, one sign bit so x1-THICK may go negative.
  localparam int CW = COORD_MAX + 2;
  localparam logic signed [CW-1:0] T = CW'(THICK);

  logic signed [CW-1:0] px, py, bx0, bx1, by0, by1;
  logic                 outer_x, outer_y, inner_x, inner_y;

  assign px  = signed'(CW'(x));
  assign py  = signed'(CW'(y));
  assign bx0 = signed'(CW'(box.x0));
  assign bx1 = signed'(CW'(box.x1));
  assign by0 = signed'(CW'(box.y0));
  assign by1 = signed'(CW'(box.y1));

  assign outer_x = (px >= bx0) && (px <= bx1);
  assign outer_y = (py >= by0) && (py <= by1);
  // An empty inner range (box narrower than 2*THICK) leaves the whole box filled.
  assign inner_x = (px >= bx0 + T) && (px <= bx1 - T);
  assign inner_y = (py >= by0 + T) && (py <= by1 - T);

  assign hit = box.en && outer_x && outer_y && !(inner_x && inner_y);

endmodule

`default_nettype wire

// File: rtl/hog_box_overlay.sv
// hog_box_overlay: draws BOX_COLOR borders around up to NBOX detection windows on a
// VGA pixel stream; the box table is double-buffered and swapped at frame start.
`default_nettype none

module hog_box_overlay
  import hog_overlay_pkg::*;
#(
  parameter int          NBOX      = 8,
  parameter int          XW        = XW_DEF,
  parameter int          YW        = YW_DEF,
  parameter int          THICK     = 2,
  parameter logic [23:0] BOX_COLOR = 24'hFF0000,
  parameter bit          SYNC_POL  = 1'b0,
  localparam int         IW        = (NBOX > 1) ? $clog2(NBOX) : 1
) (
  input  logic          vga_clk,
  input  logic          vga_rst,
  input  logic          box_wr_valid,
  output logic          box_wr_ready,
  input  logic [IW-1:0] box_wr_idx,
  input  logic          box_wr_en,
  input  logic [XW-1:0] box_wr_x0,
  input  logic [XW-1:0] box_wr_x1,
  input  logic [YW-1:0] box_wr_y0,
  input  logic [YW-1:0] box_wr_y1,
  input  logic          box_commit,
  output logic          box_pending,
  input  logic [7:0]    in_red,
  input  logic [7:0]    in_green,
  input  logic [7:0]    in_blue,
  input  logic          in_hsync,
  input  logic          in_vsync,
  input  logic          in_de,
  output logic [7:0]    out_red,
  output logic [7:0]    out_green,
  output logic [7:0]    out_blue,
  output logic          out_hsync,
  output logic          out_vsync,
  output logic          out_de
);

  box_t          shadow_tbl [NBOX];
  box_t          active_tbl [NBOX];
  box_t          wr_box;
  commit_state_t state, state_nxt;

  logic            vs_act, vs_act_d, frame_start, copy, wr_accept;
  logic [XW-1:0]   x_cnt;
  logic [YW-1:0]   y_cnt;
  logic            de_d;
  logic [NBOX-1:0] hit_vec, hit_s1;
  logic [23:0]     rgb_s1;
  logic            hs_s1, vs_s1, de_s1;

  assign vs_act      = (in_vsync == SYNC_POL);
  assign frame_start = vs_act && !vs_act_d;
  assign wr_accept   = box_wr_valid && box_wr_ready;

  assign wr_box = '{en: box_wr_en,
                    x0: COORD_MAX'(box_wr_x0), y0: COORD_MAX'(box_wr_y0),
                    x1: COORD_MAX'(box_wr_x1), y1: COORD_MAX'(box_wr_y1)};

  always_ff @(posedge vga_clk) begin
    if (vga_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    copy      = 1'b0;
    case (state)
      ST_IDLE:    if (box_commit) state_nxt = ST_PENDING;
      ST_PENDING: if (frame_start) begin
        copy      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:    state_nxt = ST_IDLE;
    endcase
    box_wr_ready = !copy;
    box_pending  = (state == ST_PENDING);
  end

  // The copy reads the shadow before any same-cycle write; ready is low then anyway.
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      for (int i = 0; i < NBOX; i++) begin
        shadow_tbl[i] <= '0;
        active_tbl[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NBOX; i++) begin
        if (copy) active_tbl[i] <= shadow_tbl[i];
        if (wr_accept && box_wr_idx == IW'(i)) shadow_tbl[i] <= wr_box;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      de_d     <= 1'b0;
      vs_act_d <= 1'b0;
    end else begin
      de_d     <= in_de;
      vs_act_d <= vs_act;
      if (!in_de)            x_cnt <= '0;
      else if (x_cnt != '1)  x_cnt <= x_cnt + XW'(1);
      if (frame_start)                            y_cnt <= '0;
      else if (de_d && !in_de && y_cnt != '1)     y_cnt <= y_cnt + YW'(1);
    end
  end

  for (genvar g = 0; g < NBOX; g++) begin : g_hit
    hog_box_hit #(
      .XW    (XW),
      .YW    (YW),
      .THICK (THICK)
    ) u_hit (
      .box (active_tbl[g]),
      .x   (x_cnt),
      .y   (y_cnt),
      .hit (hit_vec[g])
    );
  end

  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      rgb_s1    <= '0;
      hs_s1     <= ~SYNC_POL;
      vs_s1     <= ~SYNC_POL;
      de_s1     <= 1'b0;
      hit_s1    <= '0;
      {out_red, out_green, out_blue} <= '0;
      out_hsync <= ~SYNC_POL;
      out_vsync <= ~SYNC_POL;
      out_de    <= 1'b0;
    end else begin
      rgb_s1    <= {in_red, in_green, in_blue};
      hs_s1     <= in_hsync;
      vs_s1     <= in_vsync;
      de_s1     <= in_de;
      hit_s1    <= hit_vec;
      {out_red, out_green, out_blue} <= (de_s1 && |hit_s1) ? BOX_COLOR : rgb_s1;
      out_hsync <= hs_s1;
      out_vsync <= vs_s1;
      out_de    <= de_s1;
    end
  end

endmodule

`default_nettype wire
